sort3_pipe: RTL and testbench
=============================

SORT3_PIPE -- requirements
Module: sort3_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: sample width in bits; legal values 2..32.
REQ-002 SHALL provide parameter SIGNED, default 0: 0 selects unsigned compare, 1 selects two's-complement compare.
REQ-003 SHALL provide port iClk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port iRst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port iValid, input, 1 bit: the input triple is valid.
REQ-006 SHALL provide port oReady, output, 1 bit: the block accepts a triple this cycle.
REQ-007 SHALL provide ports iNum1, iNum2, iNum3, input, WIDTH bits each: the input triple, with indices 0, 1 and 2 respectively.
REQ-008 SHALL provide port oValid, output, 1 bit: the output triple is valid.
REQ-009 SHALL provide port iReady, input, 1 bit: the downstream block accepts the output this cycle.
REQ-010 SHALL provide ports oMin, oMed, oMax, output, WIDTH bits each: the sorted triple.

Function
REQ-011 SHALL sort in three registered compare-swap stages:
- S1: cas(n1, n2)
- S2: cas(pos1, pos2)
- S3: cas(pos0, pos1)
REQ-012 Each compare-swap SHALL keep the current order when lower <= upper and swap otherwise (stable; equal values keep input-index order).
REQ-013 Comparison SHALL be unsigned when SIGNED=0 and signed when SIGNED=1; data SHALL pass unmodified, with no width growth.
REQ-014 Pipeline advance enable SHALL be adv = !oValid || iReady; oReady SHALL equal adv, combinationally.
REQ-015 When adv=1, every stage SHALL load from its predecessor, and the S1 valid bit SHALL load iValid.
REQ-016 When adv=0, all data and valid registers SHALL hold.
REQ-017 A triple is accepted on a cycle with iValid && oReady, and SHALL appear on oValid/oMin/oMed/oMax exactly 3 cycles later when adv stays 1.
REQ-018 Throughput SHALL be one triple per cycle with no bubbles inserted.
REQ-019 oValid with unchanged outputs SHALL hold until the cycle iValid... correction: until a cycle with iReady=1; outputs SHALL NOT change while oValid && !iReady.
REQ-020 Bubbles (iValid=0 while accepted) SHALL propagate as valid=0; data registers in bubble slots are don't-care, but SHALL NOT raise oValid.
REQ-021 The pipeline SHALL hold at most 3 triples; there is no skid buffer, so stall propagates to oReady in the same cycle.

Reset
REQ-022 iRst=1 at a rising edge SHALL clear all stage valid bits and oValid to 0, and oMin/oMed/oMax to 0.
REQ-023 Reset SHALL override adv and iValid; in-flight triples SHALL be discarded, with no partial output.
REQ-024 In the first cycle after reset deasserts, oReady SHALL be 1.

Configuration
REQ-025 Macro SORT3_PIPE_MEDIDX_EN, when defined, SHALL add output port oMedIdx (2 bits): the input index (0..2) of the value on oMed, carried as a tag through every compare-swap, and reset to 0.
REQ-026 When SORT3_PIPE_MEDIDX_EN is undefined, oMedIdx and all tag registers SHALL be absent, with all other behaviour identical.

Verification
REQ-027 Basic sort: WIDTH=8, SIGNED=0, iReady=1, single triple (5,3,9) -> oValid 3 cycles later, oMin=3, oMed=5, oMax=9, then oValid=0.
REQ-028 Signed sort: SIGNED=1, triple (8'hFF, 8'h01, 8'h80) -> oMin=8'h80, oMed=8'hFF, oMax=8'h01; the same triple with SIGNED=0 -> 01, 80, FF.
REQ-029 Ties: triple (7,7,2) with the macro defined -> oMin=2, oMed=7, oMax=7, oMedIdx=0.
REQ-030 Backpressure: stream (1,2,3), (6,5,4), (9,8,7) back-to-back; drop iReady to 0 when the first output is valid, for 4 cycles:
- oReady=0 and outputs frozen at (1,2,3) during the stall;
- after release, outputs (1,2,3), (4,5,6), (7,8,9) appear on consecutive cycles, with none lost or duplicated.
REQ-031 Reset mid-operation: two triples in flight, iRst=1 for 1 cycle -> oValid=0 and outputs 0 next cycle, neither triple ever emitted, oReady=1.
REQ-032 Random: 10k random triples with random iValid/iReady, WIDTH=12 -> output order and values match a sorted reference model.

Source files
------------

// File: rtl/sort3_pipe.sv
// Three-stage pipelined sorter for a triple of samples with valid/ready flow control.
// Optional SORT3_PIPE_MEDIDX_EN adds oMedIdx, the input index of the median value.
module sort3_pipe #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iNum1,
    input  logic [WIDTH-1:0] iNum2,
    input  logic [WIDTH-1:0] iNum3,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oMin,
    output logic [WIDTH-1:0] oMed,
    output logic [WIDTH-1:0] oMax
`ifdef SORT3_PIPE_MEDIDX_EN
    ,
    output logic [1:0]       oMedIdx
`endif
);

    logic                  adv;
    logic                  v1;
    logic                  v2;
    logic [2:0][WIDTH-1:0] s1;
    logic [2:0][WIDTH-1:0] s2;
    logic                  swap1;
    logic                  swap2;
    logic                  swap3;

    // Strict greater-than: equal values never swap, which keeps the sort stable.
    function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) return $signed(a) > $signed(b);
        else        return a > b;
    endfunction

    assign adv    = !oValid || iReady;
    assign oReady = adv;

    assign swap1 = gt(iNum1, iNum2);
    assign swap2 = gt(s1[1], s1[2]);
    assign swap3 = gt(s2[0], s2[1]);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            oValid <= 1'b0;
            s1     <= '0;
            s2     <= '0;
            oMin   <= '0;
            oMed   <= '0;
            oMax   <= '0;
        end else if (adv) begin
            v1     <= iValid;
            v2     <= v1;
            oValid <= v2;

            s1[0]  <= swap1 ? iNum2 : iNum1;
            s1[1]  <= swap1 ? iNum1 : iNum2;
            s1[2]  <= iNum3;

            s2[0]  <= s1[0];
            s2[1]  <= swap2 ? s1[2] : s1[1];
            s2[2]  <= swap2 ? s1[1] : s1[2];

            oMin   <= swap3 ? s2[1] : s2[0];
            oMed   <= swap3 ? s2[0] : s2[1];
            oMax   <= s2[2];
        end
    end

`ifdef SORT3_PIPE_MEDIDX_EN
    logic [2:0][1:0] t1;
    logic [1:0][1:0] t2;

    // Index tags ride alongside the data; the max tag is never needed at the output.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            t1      <= '0;
            t2      <= '0;
            oMedIdx <= 2'd0;
        end else if (adv) begin
            t1[0]   <= swap1 ? 2'd1 : 2'd0;
            t1[1]   <= swap1 ? 2'd0 : 2'd1;
            t1[2]   <= 2'd2;
            t2[0]   <= t1[0];
            t2[1]   <= swap2 ? t1[2] : t1[1];
            oMedIdx <= swap3 ? t2[0] : t2[1];
        end
    end
`endif

endmodule

// File: tb/tb_sort3_pipe.sv
// Self-checking bench for sort3_pipe: directed cases on 8-bit instances,
// randomized valid/ready traffic on a 12-bit instance against a rank-based model.
module tb_sort3_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed instances (shared stimulus) ----------------
    logic       dRst, dV, dR;
    logic [7:0] d1, d2, d3;
    logic       uV, uRdy, sV, sRdy;
    logic [7:0] uMin, uMed, uMax, sMin, sMed, sMax;
`ifdef SORT3_PIPE_MEDIDX_EN
    logic [1:0] uIdx, sIdx;
`endif

    sort3_pipe #(.WIDTH(8), .SIGNED(1'b0)) uU (
        .iClk(clk), .iRst(dRst), .iValid(dV), .oReady(uRdy),
        .iNum1(d1), .iNum2(d2), .iNum3(d3),
        .oValid(uV), .iReady(dR),
        .oMin(uMin), .oMed(uMed), .oMax(uMax)
`ifdef SORT3_PIPE_MEDIDX_EN
        , .oMedIdx(uIdx)
`endif
    );

    sort3_pipe #(.WIDTH(8), .SIGNED(1'b1)) uS (
        .iClk(clk), .iRst(dRst), .iValid(dV), .oReady(sRdy),
        .iNum1(d1), .iNum2(d2), .iNum3(d3),
        .oValid(sV), .iReady(dR),
        .oMin(sMin), .oMed(sMed), .oMax(sMax)
`ifdef SORT3_PIPE_MEDIDX_EN
        , .oMedIdx(sIdx)
`endif
    );

    // ---------------- random instance ----------------
    logic        rRst, rV, rR;
    logic [11:0] r1, r2, r3;
    logic        wV, wRdy;
    logic [11:0] wMin, wMed, wMax;
`ifdef SORT3_PIPE_MEDIDX_EN
    logic [1:0]  wIdx;
`endif

    sort3_pipe #(.WIDTH(12), .SIGNED(1'b0)) uR (
        .iClk(clk), .iRst(rRst), .iValid(rV), .oReady(wRdy),
        .iNum1(r1), .iNum2(r2), .iNum3(r3),
        .oValid(wV), .iReady(rR),
        .oMin(wMin), .oMed(wMed), .oMax(wMax)
`ifdef SORT3_PIPE_MEDIDX_EN
        , .oMedIdx(wIdx)
`endif
    );

    typedef struct {
        logic [11:0] mn;
        logic [11:0] md;
        logic [11:0] mx;
        logic [1:0]  mi;
    } exp_t;

    // Stable sort by rank: ties ordered by input index.
    function automatic exp_t sortRef(input logic [11:0] a, input logic [11:0] b,
                                     input logic [11:0] c);
        logic [11:0] v[3];
        exp_t        e;
        int          rk;
        v[0] = a; v[1] = b; v[2] = c;
        e.mn = '0; e.md = '0; e.mx = '0; e.mi = '0;
        for (int i = 0; i < 3; i++) begin
            rk = 0;
            for (int j = 0; j < 3; j++)
                if (v[j] < v[i] || (v[j] == v[i] && j < i)) rk++;
            case (rk)
                0: e.mn = v[i];
                1: begin e.md = v[i]; e.mi = 2'(i); end
                default: e.mx = v[i];
            endcase
        end
        return e;
    endfunction

    exp_t        q[$];
    int          popped = 0;
    logic        prevStall = 1'b0;
    logic [35:0] prevOut = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rRst) begin
            q.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                chk("rnd_hold_valid", 32'(wV), 32'd1);
                chk("rnd_hold_data", 32'({wMin, wMed, wMax} != prevOut), 32'd0);
            end
            chk("rnd_ready", 32'(wRdy), 32'(!wV || rR));
            if (wV && rR) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    popped++;
                    chk("rnd_min", 32'(wMin), 32'(e.mn));
                    chk("rnd_med", 32'(wMed), 32'(e.md));
                    chk("rnd_max", 32'(wMax), 32'(e.mx));
`ifdef SORT3_PIPE_MEDIDX_EN
                    chk("rnd_medidx", 32'(wIdx), 32'(e.mi));
`endif
                end
            end
            if (rV && wRdy) q.push_back(sortRef(r1, r2, r3));
            chk("rnd_occupancy", 32'(q.size() <= 3), 32'd1);
            prevStall = wV && !rR;
            prevOut   = {wMin, wMed, wMax};
        end
    end

    task automatic chkU(input string nm, input logic [7:0] mn, input logic [7:0] md,
                        input logic [7:0] mx);
        chk({nm, "_valid"}, 32'(uV), 32'd1);
        chk({nm, "_min"}, 32'(uMin), 32'(mn));
        chk({nm, "_med"}, 32'(uMed), 32'(md));
        chk({nm, "_max"}, 32'(uMax), 32'(mx));
    endtask

    task automatic chkS(input string nm, input logic [7:0] mn, input logic [7:0] md,
                        input logic [7:0] mx);
        chk({nm, "_valid"}, 32'(sV), 32'd1);
        chk({nm, "_min"}, 32'(sMin), 32'(mn));
        chk({nm, "_med"}, 32'(sMed), 32'(md));
        chk({nm, "_max"}, 32'(sMax), 32'(mx));
    endtask

    task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        d1 = a; d2 = b; d3 = c; dV = 1'b1;
        step();
        dV = 1'b0;
        chk("lat_c1", 32'(uV), 32'd0);
        step();
        chk("lat_c2", 32'(uV), 32'd0);
        step();
    endtask

    initial begin
        exp_t e;
        int   accepted;
        int   cyc;
        logic acc;

        dRst = 1'b1; dV = 1'b0; dR = 1'b0; d1 = '0; d2 = '0; d3 = '0;
        rRst = 1'b1; rV = 1'b0; rR = 1'b1; r1 = '0; r2 = '0; r3 = '0;

        e = sortRef(12'd5, 12'd3, 12'd9);
        chk("model_a", {e.mn[7:0], e.md[7:0], e.mx[7:0]}, 32'h030509);
        e = sortRef(12'd7, 12'd7, 12'd2);
        chk("model_tie", {e.mn[7:0], e.md[7:0], e.mx[7:0], 6'd0, e.mi}, 32'h02070700);
        e = sortRef(12'd4, 12'd4, 12'd4);
        chk("model_eq_idx", 32'(e.mi), 32'd1);

        step();
        step();
        dRst = 1'b0;
        rRst = 1'b0;
        #1;
        chk("rst_valid", 32'(uV), 32'd0);
        chk("rst_data", 32'({uMin, uMed, uMax}), 32'd0);
        chk("rst_ready", 32'(uRdy), 32'd1);
        dR = 1'b1;

        single(8'd5, 8'd3, 8'd9);
        chkU("basic", 8'd3, 8'd5, 8'd9);
        chkS("basic_s", 8'd3, 8'd5, 8'd9);
        step();
        chk("basic_after", 32'(uV), 32'd0);

        single(8'hFF, 8'h01, 8'h80);
        chkU("uns", 8'h01, 8'h80, 8'hFF);
        chkS("sgn", 8'h80, 8'hFF, 8'h01);
        step();

        single(8'd7, 8'd7, 8'd2);
        chkU("tie", 8'd2, 8'd7, 8'd7);
`ifdef SORT3_PIPE_MEDIDX_EN
        chk("tie_medidx", 32'(uIdx), 32'd0);
`endif
        step();

        d1 = 8'd1; d2 = 8'd2; d3 = 8'd3; dV = 1'b1;
        step();
        d1 = 8'd6; d2 = 8'd5; d3 = 8'd4;
        step();
        d1 = 8'd9; d2 = 8'd8; d3 = 8'd7;
        step();
        dV = 1'b0;
        dR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ready", 32'(uRdy), 32'd0);
            chkU("bp_stall", 8'd1, 8'd2, 8'd3);
            step();
        end
        dR = 1'b1;
        #1;
        chk("bp_release_ready", 32'(uRdy), 32'd1);
        chkU("bp_out1", 8'd1, 8'd2, 8'd3);
        step();
        chkU("bp_out2", 8'd4, 8'd5, 8'd6);
        step();
        chkU("bp_out3", 8'd7, 8'd8, 8'd9);
        step();
        chk("bp_done", 32'(uV), 32'd0);

        d1 = 8'd11; d2 = 8'd12; d3 = 8'd13; dV = 1'b1;
        step();
        d1 = 8'd21; d2 = 8'd22; d3 = 8'd23;
        step();
        dV = 1'b0;
        dRst = 1'b1;
        step();
        dRst = 1'b0;
        chk("mrst_valid", 32'(uV), 32'd0);
        chk("mrst_data", 32'({uMin, uMed, uMax}), 32'd0);
        chk("mrst_ready", 32'(uRdy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mrst_no_emit", 32'(uV), 32'd0);
        end

        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            rV = ($urandom_range(0, 3) != 0);
            rR = ($urandom_range(0, 3) != 0);
            r1 = 12'($urandom);
            r2 = 12'($urandom);
            r3 = 12'($urandom);
            if ($urandom_range(0, 7) == 0) r2 = r1;
            #1;
            acc = rV && wRdy;
            step();
            if (acc) accepted++;
            cyc++;
        end
        rV = 1'b0;
        rR = 1'b1;
        repeat (8) step();
        chk("rnd_accepted", 32'(accepted), 32'd10000);
        chk("rnd_drained", 32'(q.size()), 32'd0);
        chk("rnd_popped", 32'(popped), 32'(accepted));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
